// File: rtl/weight_row_classifier.sv
// Output-layer engine: walks the weight ROM, popcount-scores each row against a latched image, reports argmax.
// Optional WEIGHT_ROW_CLASSIFIER_XNOR_EN selects XNOR matching (bipolar net); default is AND matching.
module weight_row_classifier #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_CLASSES = 10,
  parameter int ADDR_W      = 10,
  parameter int SCORE_W     = 10,
  parameter int CLASS_W     = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [NUM_INPUTS-1:0] pixels_i,
  input  logic [NUM_INPUTS-1:0] weight_i,
  output logic [ADDR_W-1:0]     rom_addr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CLASS_W-1:0]    class_o,
  output logic [SCORE_W-1:0]    score_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CLASS_W-1:0] LAST_ISSUE = CLASS_W'(NUM_CLASSES - 2);
  localparam logic [CLASS_W-1:0] LAST_SCORE = CLASS_W'(NUM_CLASSES);

  state_t                r_state;
  state_t                w_next;
  logic [NUM_INPUTS-1:0] r_pix;
  logic [ADDR_W-1:0]     r_addr;
  logic [CLASS_W-1:0]    r_cnt;
  logic [SCORE_W-1:0]    r_best_score;
  logic [CLASS_W-1:0]    r_best_class;
  logic                  r_done;
  logic [CLASS_W-1:0]    r_class;
  logic [SCORE_W-1:0]    r_score;

  logic                  w_accept;
  logic                  w_score_vld;
  logic                  w_last;
  logic                  w_take;
  logic [CLASS_W-1:0]    w_k;
  logic [NUM_INPUTS-1:0] w_match;
  logic [SCORE_W-1:0]    w_score;

  function automatic logic [SCORE_W-1:0] popcount(input logic [NUM_INPUTS-1:0] v);
    logic [SCORE_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      c = c + SCORE_W'(v[i]);
    end
    return c;
  endfunction

`ifdef WEIGHT_ROW_CLASSIFIER_XNOR_EN
  assign w_match = ~(r_pix ^ weight_i);
`else
  assign w_match = r_pix & weight_i;
`endif

  // r_cnt counts edges since the accepted start; row k arrives when r_cnt == k+1.
  assign w_accept    = (r_state == S_IDLE) && start_i;
  assign w_score_vld = (r_state != S_IDLE) && (r_cnt != '0);
  assign w_k         = r_cnt - CLASS_W'(1);
  assign w_score     = popcount(w_match);
  assign w_take      = (w_k == '0) || (w_score > r_best_score);
  assign w_last      = (r_state == S_DRAIN) && (r_cnt == LAST_SCORE);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_FETCH;
      S_FETCH: if (r_cnt == LAST_ISSUE) w_next = S_DRAIN;
      S_DRAIN: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pix        <= '0;
      r_addr       <= '0;
      r_cnt        <= '0;
      r_best_score <= '0;
      r_best_class <= '0;
      r_done       <= 1'b0;
      r_class      <= '0;
      r_score      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_pix        <= pixels_i;
        r_addr       <= '0;
        r_cnt        <= '0;
        r_best_score <= '0;
        r_best_class <= '0;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + CLASS_W'(1);
        if (r_state == S_FETCH) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
        if (w_score_vld && w_take) begin
          r_best_score <= w_score;
          r_best_class <= w_k;
        end
        // The last row is folded in directly so results land on the done edge.
        if (w_last) begin
          r_done  <= 1'b1;
          r_addr  <= '0;
          r_class <= w_take ? w_k : r_best_class;
          r_score <= w_take ? w_score : r_best_score;
        end
      end
    end
  end

  assign rom_addr_o = r_addr;
  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign class_o    = r_class;
  assign score_o    = r_score;

endmodule

// File: tb/tb_weight_row_classifier.sv
// Bench for weight_row_classifier: registered ROM model, argmax reference, directed and random runs.
module tb_weight_row_classifier;

  localparam int NI = 784;
  localparam int NC = 10;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [NI-1:0] pixels_i;
  logic [NI-1:0] weight_i;
  logic [9:0]    rom_addr_o;
  logic          busy_o;
  logic          done_o;
  logic [3:0]    class_o;
  logic [9:0]    score_o;

  logic [NI-1:0] rows [NC];

  int n_assert = 0;
  int n_fail   = 0;

  weight_row_classifier dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .pixels_i   (pixels_i),
    .weight_i   (weight_i),
    .rom_addr_o (rom_addr_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .class_o    (class_o),
    .score_o    (score_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    weight_i <= (rom_addr_o < 10'(NC)) ? rows[rom_addr_o] : '0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [NI-1:0] pix, output int cls, output int scr);
    logic [NI-1:0] m;
    int s;
    scr = -1;
    cls = 0;
    for (int k = 0; k < NC; k++) begin
`ifdef WEIGHT_ROW_CLASSIFIER_XNOR_EN
      m = ~(pix ^ rows[k]);
`else
      m = pix & rows[k];
`endif
      s = $countones(m);
      if (s > scr) begin
        scr = s;
        cls = k;
      end
    end
  endfunction

  function automatic logic [NI-1:0] rand_vec();
    logic [NI-1:0] v;
    for (int i = 0; i < NI; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic logic [NI-1:0] ones_vec(input int n);
    logic [NI-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic run_one(input logic [NI-1:0] pix, input int exp_cls, input int exp_scr,
                         input bit pulse_mid, input string tag);
    int  cls, scr, n;
    bit  got;
    logic [3:0] held_cls;
    model(pix, cls, scr);
    pixels_i = pix;
    start_i  = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i  = 1'b0;
    pixels_i = ~pix;
    check({tag, ".addr0"}, rom_addr_o, 0);
    check({tag, ".busy0"}, busy_o, 1);
    got = 1'b0;
    n   = 0;
    while (!got && n < 20) begin
      @(posedge clk_i);
      @(negedge clk_i);
      n++;
      if (pulse_mid) start_i = (n == 4);
      if (done_o) begin
        got = 1'b1;
      end else begin
        check({tag, ".busy"}, busy_o, 1);
        if (n <= 10) check({tag, ".addr"}, rom_addr_o, (n > 9) ? 9 : n);
      end
    end
    start_i = 1'b0;
    check({tag, ".latency"}, n, 11);
    check({tag, ".class_model"}, class_o, cls);
    check({tag, ".score_model"}, score_o, scr);
    if (exp_cls >= 0) begin
      check({tag, ".class"}, class_o, exp_cls);
      check({tag, ".score"}, score_o, exp_scr);
    end
    check({tag, ".busy_done"}, busy_o, 0);
    check({tag, ".addr_done"}, rom_addr_o, 0);
    held_cls = class_o;
    @(posedge clk_i);
    @(negedge clk_i);
    check({tag, ".done_pulse"}, done_o, 0);
    check({tag, ".class_held"}, class_o, held_cls);
    if (pulse_mid) begin
      got = 1'b0;
      repeat (12) begin
        @(posedge clk_i);
        @(negedge clk_i);
        if (busy_o) got = 1'b1;
      end
      check({tag, ".no_requeue"}, got, 0);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk_i);
      @(negedge clk_i);
      n++;
    end while (!done_o && n < 30);
  endtask

  initial begin
    logic [NI-1:0] pa, pb;
    int ca, sa, cb, sb, n;
    bit seen;

    reset_i  = 1'b1;
    start_i  = 1'b0;
    pixels_i = '0;
    for (int k = 0; k < NC; k++) rows[k] = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst.addr", rom_addr_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.done", done_o, 0);
    check("rst.class", class_o, 0);
    check("rst.score", score_o, 0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Single hot row.
    rows[7] = '1;
    run_one('1, 7, 784, 1'b0, "argmax");

    // Tie between rows 2 and 5.
    for (int k = 0; k < NC; k++) rows[k] = ones_vec(k * 7);
    rows[2] = ones_vec(100);
    rows[5] = ones_vec(100);
    run_one('1, 2, 100, 1'b0, "tie");

    // All-zero image against a single full row.
    for (int k = 0; k < NC; k++) rows[k] = '0;
    rows[3] = '1;
`ifdef WEIGHT_ROW_CLASSIFIER_XNOR_EN
    run_one('0, 0, 784, 1'b0, "zero_img");
`else
    run_one('0, 0, 0, 1'b0, "zero_img");
`endif

    // Random rows and images; one run also pulses start while busy.
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < NC; k++) rows[k] = rand_vec();
      run_one(rand_vec(), -1, 0, (t == 1), "rand");
    end

    // Back-to-back with start held high.
    pa = rand_vec();
    pb = rand_vec();
    model(pa, ca, sa);
    model(pb, cb, sb);
    pixels_i = pa;
    start_i  = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    pixels_i = pb;
    wait_done(n);
    check("b2b.lat1", n + 1, 11 + 1);
    check("b2b.class1", class_o, ca);
    check("b2b.score1", score_o, sa);
    wait_done(n);
    check("b2b.period", n, 12);
    check("b2b.class2", class_o, cb);
    check("b2b.score2", score_o, sb);
    start_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    check("b2b.stop", busy_o, 0);

    // Reset partway through a run.
    pixels_i = rand_vec();
    start_i  = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst.addr", rom_addr_o, 0);
    check("midrst.busy", busy_o, 0);
    check("midrst.done", done_o, 0);
    check("midrst.class", class_o, 0);
    check("midrst.score", score_o, 0);
    reset_i = 1'b0;
    seen = 1'b0;
    repeat (14) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (done_o || busy_o) seen = 1'b1;
    end
    check("midrst.no_done", seen, 0);
    run_one(rand_vec(), -1, 0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/weight_row_classifier.md
# weight_row_classifier

Sequencer and scorer that sits on the consumer side of the registered weight ROM (10 rows × 784 bits, address in, row out one cycle later). On a start request it latches a 784-bit binarized image, walks ROM addresses 0..NUM_CLASSES-1, scores each returned weight row against the image by popcount, and reports the argmax class and its score. It is the output-layer engine between the input image buffer and the digit-result logic.

## Interface
- NUM_INPUTS, 784, bits per image and per weight row
- NUM_CLASSES, 10, number of ROM rows / output classes
- ADDR_W, 10, ROM address width
- SCORE_W, 10, score width; must satisfy 2^SCORE_W > NUM_INPUTS
- CLASS_W, 4, class index width; must satisfy 2^CLASS_W >= NUM_CLASSES
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  request; sampled only in IDLE
- pixels_i  in  NUM_INPUTS  binarized image; latched on the accepted start edge
- weight_i  in  NUM_INPUTS  ROM row data; row for address A is valid the cycle after rom_addr_o = A
- rom_addr_o  out  ADDR_W  registered ROM address
- busy_o  out  1  high from the accepted start until done
- done_o  out  1  one-cycle pulse; class_o/score_o valid and held afterwards
- class_o  out  CLASS_W  index of the highest-scoring row
- score_o  out  SCORE_W  score of that row

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: start_i=1 at edge E0 latches pixels_i, sets rom_addr_o=0, clears best score/class, enters FETCH. busy_o=1.
- FETCH: rom_addr_o increments by 1 per edge; after issuing NUM_CLASSES-1 (edge E9), enter DRAIN.
- Scoring: at edge E(k+2), k=0..NUM_CLASSES-1, score_k = popcount(match(pixels, weight_i)) is computed and compared in the same edge; registered into best when score_k > best (strict), so ties keep the lowest index. Row 0 always loads best.
- DRAIN: holds rom_addr_o; after the final row is scored (E11), go to IDLE, pulse done_o, drop busy_o, rom_addr_o returns to 0.
- class_o/score_o update only at the done edge; held until the next done or reset.
- start_i while busy is ignored (not queued). start_i high at the done edge is ignored; a new start is accepted no earlier than the following edge.
- Popcount is full-width unsigned; no saturation needed (max NUM_INPUTS fits SCORE_W).

## Timing
- Reset values: rom_addr_o=0, busy_o=0, done_o=0, class_o=0, score_o=0, state IDLE, internal best cleared.
- Reset mid-operation aborts immediately; no done_o for the aborted run.
- Latency: accepted start edge E0 to done_o high after edge E(NUM_CLASSES+1) = 11 cycles at defaults.
- Throughput: one classification per NUM_CLASSES+2 cycles when start_i is held high.
- weight_i is consumed only on scoring edges; its value at other times is don't-care.

## Configuration
- WEIGHT_ROW_CLASSIFIER_XNOR_EN defined: match = XNOR(pixels, weight) (bipolar binary net; score = agreeing bits, both 0s and 1s count).
- Not defined: match = AND(pixels, weight) (count of lit pixels hitting set weights).

## Test plan
- Addressing: single start -> rom_addr_o shows 0,1,...,9 on consecutive cycles after E0; done_o one pulse exactly 11 cycles after start; busy_o high 11 cycles.
- Argmax: ROM model rows all 0 except row 7 all 1, pixels all 1, AND mode -> class_o=7, score_o=784.
- Tie: rows 2 and 5 identical with 100 ones overlapping pixels, others fewer -> class_o=2, score_o=100.
- XNOR mode: pixels all 0, all rows 0 except row 3 all 1 -> class_o=0, score_o=784; AND mode same stimulus -> class_o=0, score_o=0.
- Busy/done overlap: start_i held high continuously -> runs back-to-back every 12 cycles, second pixels_i latched on the edge after done; pulse on start during busy has no effect.
- Reset at cycle 5 of a run -> all outputs 0 next cycle, no done_o; next start completes normally.
